// File: rtl/pattern_driver_pkg.sv
// Shared types and default sizes for the pattern_driver vector engine.
package pattern_driver_pkg;

    localparam int PD_DATA_W = 32;
    localparam int PD_PIN_W  = 31;
    localparam int PD_PER_W  = 16;
    localparam int PD_CNT_W  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/pattern_driver_if.sv
// Vector stream from the dual-clock FIFO into pattern_driver.
// A word moves on every rising clk where in_valid and in_ready are both high; in_ready never depends on in_valid.
interface pattern_driver_if
    import pattern_driver_pkg::*;
#(
    parameter int DATA_W = PD_DATA_W
);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/pd_hold_counter.sv
// Loadable down-counter timing how long each vector is held; a zero period loads as one cycle.
module pd_hold_counter
    import pattern_driver_pkg::*;
#(
    parameter int PER_W = PD_PER_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [PER_W-1:0] period,
    output logic             zero
);

    logic [PER_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= (period == '0) ? '0 : period - PER_W'(1);
        end else if (en && cnt != '0) begin
            cnt <= cnt - PER_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/pattern_driver.sv
// Streaming test-vector driver: pops FIFO words onto the DUT pins, holding each for a programmable period.
// Optional response capture at the end of each vector is enabled by defining PATTERN_DRIVER_CAPTURE_EN.
module pattern_driver
    import pattern_driver_pkg::*;
#(
    parameter int DATA_W = PD_DATA_W,
    parameter int PIN_W  = PD_PIN_W,
    parameter int PER_W  = PD_PER_W,
    parameter int CNT_W  = PD_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [PER_W-1:0] period,
    pattern_driver_if.slave  stream,
    output logic [PIN_W-1:0] pins_out,
    output logic             pins_oe,
    input  logic [PIN_W-1:0] resp_in,
    output logic [PIN_W-1:0] resp_data,
    output logic             resp_valid,
    output logic             busy,
    output logic [CNT_W-1:0] vec_count,
    output logic             underrun,
    output state_t           state_dbg
);

    state_t state, state_next;
    logic   zero;
    logic   accept;
    logic   start;
    logic   set_underrun;
    logic   clr_pins;
    logic   last_cycle;
    logic   unused_data;

    // Gated by reset so the FIFO never pops during the cycle reset is sampled.
    assign stream.in_ready = ~reset & ((state == FETCH) | ((state == HOLD) & zero & enable));
    assign accept          = stream.in_valid & stream.in_ready;
    assign last_cycle      = (state == HOLD) & zero;
    assign busy            = (state != IDLE);
    assign state_dbg       = state;
    assign unused_data     = ^stream.in_data;

    pd_hold_counter #(.PER_W(PER_W)) u_hold_counter (
        .clk    (clk),
        .reset  (reset),
        .load   (accept),
        .en     (state == HOLD),
        .period (period),
        .zero   (zero)
    );

    always_comb begin
        state_next   = state;
        start        = 1'b0;
        set_underrun = 1'b0;
        clr_pins     = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_next = FETCH;
                    start      = 1'b1;
                end
            end
            FETCH: begin
                if (accept) begin
                    state_next = HOLD;
                end else if (enable) begin
                    set_underrun = 1'b1;
                end else begin
                    state_next = IDLE;
                    clr_pins   = 1'b1;
                end
            end
            HOLD: begin
                if (zero && !accept) begin
                    if (enable) begin
                        state_next   = FETCH;
                        set_underrun = 1'b1;
                    end else begin
                        state_next = IDLE;
                        clr_pins   = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pins_out  <= '0;
            pins_oe   <= 1'b0;
            vec_count <= '0;
            underrun  <= 1'b0;
        end else begin
            state <= state_next;
            if (start) begin
                vec_count <= '0;
                underrun  <= 1'b0;
            end
            if (accept) begin
                pins_out  <= stream.in_data[PIN_W-1:0];
                pins_oe   <= 1'b1;
                vec_count <= vec_count + CNT_W'(1);
            end else if (clr_pins) begin
                pins_out <= '0;
                pins_oe  <= 1'b0;
            end
            if (set_underrun) begin
                underrun <= 1'b1;
            end
        end
    end

`ifdef PATTERN_DRIVER_CAPTURE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_data  <= '0;
            resp_valid <= 1'b0;
        end else begin
            resp_valid <= last_cycle;
            if (last_cycle) begin
                resp_data <= resp_in;
            end
        end
    end
`else
    logic unused_resp;
    assign unused_resp = ^{resp_in, last_cycle};
    assign resp_data   = '0;
    assign resp_valid  = 1'b0;
`endif

endmodule

// File: tb/tb_pattern_driver.sv
// Directed bench for pattern_driver: stream, hold periods, starvation, stop, capture and reset.
module tb_pattern_driver;
    import pattern_driver_pkg::*;

    localparam int DATA_W = 32;
    localparam int PIN_W  = 31;
    localparam int PER_W  = 16;
    localparam int CNT_W  = 32;
`ifdef PATTERN_DRIVER_CAPTURE_EN
    localparam bit CAP = 1'b1;
`else
    localparam bit CAP = 1'b0;
`endif

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic             enable;
    logic [PER_W-1:0] period;
    logic [PIN_W-1:0] pins_out;
    logic             pins_oe;
    logic [PIN_W-1:0] resp_in;
    logic [PIN_W-1:0] resp_data;
    logic             resp_valid;
    logic             busy;
    logic [CNT_W-1:0] vec_count;
    logic             underrun;
    state_t           state_dbg;

    pattern_driver_if #(.DATA_W(DATA_W)) stream ();

    pattern_driver #(
        .DATA_W(DATA_W), .PIN_W(PIN_W), .PER_W(PER_W), .CNT_W(CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .period     (period),
        .stream     (stream),
        .pins_out   (pins_out),
        .pins_oe    (pins_oe),
        .resp_in    (resp_in),
        .resp_data  (resp_data),
        .resp_valid (resp_valid),
        .busy       (busy),
        .vec_count  (vec_count),
        .underrun   (underrun),
        .state_dbg  (state_dbg)
    );

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] words[$];
    bit starve = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // driver: present the head of the word queue unless starving
    task automatic upd();
        stream.in_valid = (words.size() != 0) && !starve;
        stream.in_data  = (words.size() != 0) ? words[0] : '0;
    endtask

    // one clock; pop the head if it was handshaken at this edge
    task automatic cyc();
        bit hs;
        hs = stream.in_valid && stream.in_ready;
        @(posedge clk);
        #1;
        if (hs && words.size() != 0) void'(words.pop_front());
        upd();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        enable  = 1'b0;
        period  = 16'd3;
        resp_in = '0;
        upd();
        repeat (3) cyc();
        chk("rst_pins", pins_out, 0);
        chk("rst_oe", pins_oe, 0);
        chk("rst_ready", stream.in_ready, 0);
        chk("rst_rvalid", resp_valid, 0);
        chk("rst_rdata", resp_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", vec_count, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_state", state_dbg, IDLE);
        reset = 1'b0;
        cyc();

        // back-to-back stream, period 3
        period = 16'd3;
        words = '{32'h1, 32'h2, 32'h3, 32'h4};
        upd();
        enable = 1'b1;
        cyc();
        chk("t1_state_fetch", state_dbg, FETCH);
        chk("t1_busy", busy, 1);
        chk("t1_oe_fetch", pins_oe, 0);
        chk("t1_ready_fetch", stream.in_ready, 1);
        for (int i = 0; i < 12; i++) begin
            cyc();
            chk($sformatf("t1_pins_%0d", i), pins_out, (i / 3) + 1);
            chk($sformatf("t1_oe_%0d", i), pins_oe, 1);
            chk($sformatf("t1_ready_%0d", i), stream.in_ready, ((i % 3) == 2 && i < 9) ? 1 : 0);
            if (i == 9) enable = 1'b0;
        end
        chk("t1_count", vec_count, 4);
        chk("t1_underrun", underrun, 0);
        cyc();
        chk("t1_stop_pins", pins_out, 0);
        chk("t1_stop_oe", pins_oe, 0);
        chk("t1_stop_busy", busy, 0);
        chk("t1_stop_state", state_dbg, IDLE);

        // period 0 behaves as period 1
        period = 16'd0;
        words = '{32'hA, 32'hB};
        upd();
        enable = 1'b1;
        cyc();
        chk("t2_count_clear", vec_count, 0);
        cyc();
        chk("t2_pins_a", pins_out, 32'hA);
        chk("t2_ready_a", stream.in_ready, 1);
        cyc();
        chk("t2_pins_b", pins_out, 32'hB);
        chk("t2_count", vec_count, 2);
        enable = 1'b0;
        cyc();
        chk("t2_stop_oe", pins_oe, 0);
        chk("t2_stop_state", state_dbg, IDLE);

        // starvation after the second vector
        period = 16'd2;
        words = '{32'h11, 32'h22, 32'h33};
        upd();
        enable = 1'b1;
        cyc();
        cyc();
        chk("t3_pins_1", pins_out, 32'h11);
        cyc();
        starve = 1'b1;
        cyc();
        chk("t3_pins_2", pins_out, 32'h22);
        cyc();
        chk("t3_underrun_pre", underrun, 0);
        cyc();
        chk("t3_state_fetch", state_dbg, FETCH);
        chk("t3_underrun", underrun, 1);
        chk("t3_hold_pins", pins_out, 32'h22);
        chk("t3_hold_oe", pins_oe, 1);
        cyc();
        cyc();
        chk("t3_still_pins", pins_out, 32'h22);
        chk("t3_ready_wait", stream.in_ready, 1);
        starve = 1'b0;
        upd();
        cyc();
        chk("t3_pins_3", pins_out, 32'h33);
        chk("t3_count", vec_count, 3);
        enable = 1'b0;
        cyc();
        cyc();
        chk("t3_stop_state", state_dbg, IDLE);
        chk("t3_stop_pins", pins_out, 0);
        chk("t3_underrun_sticky", underrun, 1);

        // graceful stop mid-vector, period 4
        period = 16'd4;
        words = '{32'h44, 32'h55};
        upd();
        enable = 1'b1;
        cyc();
        chk("t4_underrun_clear", underrun, 0);
        cyc();
        chk("t4_pins_c1", pins_out, 32'h44);
        cyc();
        chk("t4_pins_c2", pins_out, 32'h44);
        enable = 1'b0;
        cyc();
        chk("t4_pins_c3", pins_out, 32'h44);
        cyc();
        chk("t4_pins_c4", pins_out, 32'h44);
        chk("t4_ready_last", stream.in_ready, 0);
        chk("t4_state_last", state_dbg, HOLD);
        cyc();
        chk("t4_stop_pins", pins_out, 0);
        chk("t4_stop_oe", pins_oe, 0);
        chk("t4_stop_busy", busy, 0);
        chk("t4_count", vec_count, 1);
        words.delete();
        upd();

        // response capture at the last cycle of each vector
        period = 16'd2;
        words = '{32'h1, 32'h2};
        upd();
        resp_in = '0;
        enable = 1'b1;
        cyc();
        cyc();
        chk("t5_rvalid_c1", resp_valid, 0);
        cyc();
        chk("t5_rvalid_c2", resp_valid, 0);
        resp_in = 31'h5A5A;
        cyc();
        chk("t5_rvalid_v1", resp_valid, CAP ? 1 : 0);
        chk("t5_rdata_v1", resp_data, CAP ? 31'h5A5A : 31'h0);
        chk("t5_pins_v2", pins_out, 32'h2);
        resp_in = 31'h1111;
        cyc();
        chk("t5_rvalid_mid", resp_valid, 0);
        resp_in = 31'h1234;
        enable = 1'b0;
        cyc();
        chk("t5_rvalid_v2", resp_valid, CAP ? 1 : 0);
        chk("t5_rdata_v2", resp_data, CAP ? 31'h1234 : 31'h0);
        chk("t5_stop_pins", pins_out, 0);
        resp_in = '0;
        cyc();
        chk("t5_rvalid_end", resp_valid, 0);

        // reset during HOLD, then restart
        period = 16'd4;
        words = '{32'h77, 32'h88};
        upd();
        enable = 1'b1;
        cyc();
        cyc();
        chk("t6_pins_pre", pins_out, 32'h77);
        chk("t6_count_pre", vec_count, 1);
        reset = 1'b1;
        cyc();
        chk("t6_rst_pins", pins_out, 0);
        chk("t6_rst_oe", pins_oe, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_count", vec_count, 0);
        chk("t6_rst_state", state_dbg, IDLE);
        chk("t6_rst_ready", stream.in_ready, 0);
        chk("t6_rst_rvalid", resp_valid, 0);
        chk("t6_rst_underrun", underrun, 0);
        reset = 1'b0;
        cyc();
        chk("t6_restart_state", state_dbg, FETCH);
        chk("t6_restart_count", vec_count, 0);
        cyc();
        chk("t6_restart_pins", pins_out, 32'h88);
        chk("t6_restart_count1", vec_count, 1);
        enable = 1'b0;
        repeat (4) cyc();
        chk("t6_end_state", state_dbg, IDLE);
        chk("t6_end_oe", pins_oe, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
